// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port synchronous data memory between two requesters
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;
  state_t state_q, state_d;
  logic sel_q, sel_d, last_q, last_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  logic e0, e1, gnt;
  // a port is masked during its own ack cycle so a held req is not re-granted with stale fields
  assign e0  = r0_req & ~r0_ack_q;
  assign e1  = r1_req & ~r1_ack_q;
  assign gnt = (e0 & e1) ? ~last_q : e1;
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    r0_ack_d    = 1'b0;
    r1_ack_d    = 1'b0;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    case (state_q)
      IDLE: if (e0 | e1) begin
        sel_d       = gnt;
        last_d      = gnt;
        mem_en_d    = 1'b1;
        mem_we_d    = gnt ? r1_we : r0_we;
        mem_addr_d  = gnt ? r1_addr : r0_addr;
        mem_wdata_d = gnt ? r1_wdata : r0_wdata;
        state_d     = ACCESS;
      end
      ACCESS: begin
        r0_ack_d = mem_we_q & ~sel_q;
        r1_ack_d = mem_we_q & sel_q;
        state_d  = mem_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        r0_ack_d   = ~sel_q;
        r1_ack_d   = sel_q;
        r0_rdata_d = sel_q ? r0_rdata_q : mem_rdata;
        r1_rdata_d = sel_q ? mem_rdata : r1_rdata_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      r0_ack_q    <= r0_ack_d;
      r1_ack_q    <= r1_ack_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
endmodule
